// File: rtl/pipeline_job_feeder_pkg.sv
// pipeline_job_feeder_pkg: shared result-field layout, word width and FSM encoding
package pipeline_job_feeder_pkg;
    localparam int BOT_W = 128;
    localparam int SUMMED_LSB = 0;
    localparam int SUMMED_W = 38;
    localparam int PCOEFF_LSB = 38;
    localparam int PCOEFF_W = 3;
    typedef enum logic [2:0] {IDLE, SEND_TOP, SEND_BOTS, DRAIN, REPORT} feederState_t;
endpackage

// File: rtl/pipeline_job_feeder_result_accumulator.sv
// feeder_result_accumulator: splits kernel results, sums fields, counts replies, flags stray results
module feeder_result_accumulator
    import pipeline_job_feeder_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SUM_W = 64,
    parameter int PC_W = 40
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clear,
    input  logic             resultFire,
    input  logic             haveOutstanding,
    input  logic [63:0]      result,
    output logic [CNT_W-1:0] received,
    output logic [CNT_W-1:0] receivedNext,
    output logic [SUM_W-1:0] sum,
    output logic [PC_W-1:0]  pcoeff,
    output logic             protocolError
);
    logic take;
    logic unusedDebug;
    assign take = resultFire && haveOutstanding;
    assign receivedNext = received + CNT_W'(take);
    assign unusedDebug = ^result[63:PCOEFF_LSB+PCOEFF_W];
    // accumulate only results that answer an issued bot; a new job restarts the totals
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            received <= '0;
            sum <= '0;
            pcoeff <= '0;
        end else if (take) begin
            received <= receivedNext;
            sum <= sum + SUM_W'(result[SUMMED_LSB +: SUMMED_W]);
            pcoeff <= pcoeff + PC_W'(result[PCOEFF_LSB +: PCOEFF_W]);
        end
    end
    // a result with nothing outstanding is a kernel fault; it stays flagged until reset
    always_ff @(posedge clock) begin
        if (rst)
            protocolError <= 1'b0;
        else if (resultFire && !haveOutstanding)
            protocolError <= 1'b1;
    end
endmodule

// File: rtl/pipeline_job_feeder.sv
// pipeline_job_feeder: feeds a job's top word and bot stream to the pipeline kernel and totals its results
module pipeline_job_feeder
    import pipeline_job_feeder_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int MAX_OUTSTANDING = 64,
    parameter int SUM_W = 64,
    parameter int PC_W = 40
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [BOT_W-1:0] job_top,
    input  logic [CNT_W-1:0] job_bot_count,
    input  logic             bot_valid,
    output logic             bot_ready,
    input  logic [BOT_W-1:0] bot_data,
    output logic             k_ivalid,
    input  logic             k_oready,
    output logic             k_start_new_top,
    output logic [63:0]      k_bot_lower,
    output logic [63:0]      k_bot_upper,
    input  logic             k_ovalid,
    output logic             k_iready,
    input  logic [63:0]      k_result,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [SUM_W-1:0] done_sum,
    output logic [PC_W-1:0]  done_pcoeff,
    output logic [CNT_W-1:0] done_bots,
    output logic             protocol_error
);
    feederState_t state, nextState;
    logic [BOT_W-1:0] topReg;
    logic [CNT_W-1:0] countReg, issued, issuedNext, received, receivedNext, outstanding;
    logic notFull, jobFire, issueFire, resultFire;

    assign outstanding = issued - received;
    // one extra bit so a window of exactly 2^CNT_W still compares correctly
    assign notFull = {1'b0, outstanding} < (CNT_W+1)'(MAX_OUTSTANDING);
    assign jobFire = job_valid && job_ready;
    assign issueFire = state == SEND_BOTS && k_ivalid && k_oready;
    assign resultFire = k_ovalid && k_iready;
    assign issuedNext = issued + CNT_W'(issueFire);
    assign done_bots = received;

    feeder_result_accumulator #(.CNT_W(CNT_W), .SUM_W(SUM_W), .PC_W(PC_W)) acc (
        .clock(clock),
        .rst(rst),
        .clear(jobFire),
        .resultFire(resultFire),
        .haveOutstanding(outstanding != '0),
        .result(k_result),
        .received(received),
        .receivedNext(receivedNext),
        .sum(done_sum),
        .pcoeff(done_pcoeff),
        .protocolError(protocol_error)
    );

    // state register
    always_ff @(posedge clock) state <= rst ? IDLE : nextState;

    // job registers and issue counter
    always_ff @(posedge clock) begin
        if (rst) begin
            topReg <= '0;
            countReg <= '0;
            issued <= '0;
        end else if (jobFire) begin
            topReg <= job_top;
            countReg <= job_bot_count;
            issued <= '0;
        end else if (issueFire) begin
            issued <= issuedNext;
        end
    end

    // next state; completion tests use the post-update counts so DRAIN can be skipped
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (job_valid) nextState = job_bot_count == '0 ? REPORT : SEND_TOP;
            SEND_TOP:  if (k_oready) nextState = SEND_BOTS;
            SEND_BOTS: if (issuedNext == countReg) nextState = receivedNext == countReg ? REPORT : DRAIN;
            DRAIN:     if (receivedNext == countReg) nextState = REPORT;
            REPORT:    if (done_ready) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // handshake outputs, all quiet during reset; bot data passes straight through
    always_comb begin
        job_ready = !rst && state == IDLE;
        k_start_new_top = !rst && state == SEND_TOP;
        bot_ready = !rst && state == SEND_BOTS && k_oready && notFull;
        k_ivalid = k_start_new_top || (!rst && state == SEND_BOTS && bot_valid && notFull);
        k_iready = !rst && state != REPORT;
        done_valid = !rst && state == REPORT;
        {k_bot_upper, k_bot_lower} = k_start_new_top ? topReg : bot_data;
    end
endmodule
